// File: rtl/hist_pkg.sv
// hist_pkg: shared defaults, FSM encoding and saturation constant for the histogram RAM controller.
package hist_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;
    localparam logic [DEF_DATA_W-1:0] SAT_ONES = '1;
    typedef enum logic [2:0] {IDLE, INC_RD, INC_WR, CLR, DMP_RD, DMP_HOLD} state_t;
endpackage

// File: rtl/histogram_ram_controller_if.sv
// histogram_ram_controller_if: RAM port and dump stream between the controller and its neighbours.
interface histogram_ram_controller_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    modport master (
        output ram_addr, ram_we, ram_wdata, dump_valid, dump_addr, dump_data,
        input  ram_rdata, dump_ready
    );
    modport slave (
        input  ram_addr, ram_we, ram_wdata, dump_valid, dump_addr, dump_data,
        output ram_rdata, dump_ready
    );
endinterface

// File: rtl/inc_fifo.sv
// inc_fifo: synchronous FIFO of pending bin-increment addresses; DEPTH must be a power of two.
module inc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= push_i ? wr_q + 1'b1 : wr_q;
            rd_q <= pop_i ? rd_q + 1'b1 : rd_q;
        end
    end

    // Extra pointer bit separates full from empty when the indices coincide.
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign head_o  = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/histogram_ram_controller.sv
// histogram_ram_controller: queues bin increments as saturating read-modify-writes and
// sequences whole-memory clear and streamed readout with optional clear-on-read.
module histogram_ram_controller
    import hist_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_valid,
    input  logic [ADDR_W-1:0] inc_addr,
    input  logic              clear_start,
    input  logic              dump_start,
    input  logic              clear_on_read,
    output logic              busy,
    output logic              fifo_full,
    output logic [15:0]       drop_count,
    histogram_ram_controller_if.master bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, inc_addr_q, inc_addr_d, head;
    logic              cor_q, cor_d, fresh_q, push, pop, empty;
    logic [DATA_W-1:0] data_q;
    logic [15:0]       drop_q;

    // A full queue still accepts a push in the same cycle it is popped.
    assign push = inc_valid && (!fifo_full || pop);

    inc_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .din_i(inc_addr),
        .full_o(fifo_full), .empty_o(empty), .head_o(head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            inc_addr_q <= '0;
            cor_q      <= 1'b0;
            fresh_q    <= 1'b0;
            data_q     <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inc_addr_q <= inc_addr_d;
            cor_q      <= cor_d;
            fresh_q    <= state_q == DMP_RD;
            data_q     <= bus.dump_data;
            drop_q     <= (inc_valid && !push && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        inc_addr_d = inc_addr_q;
        cor_d      = cor_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = CLR;
                    addr_d  = '0;
                end else if (dump_start) begin
                    state_d = DMP_RD;
                    addr_d  = '0;
                    cor_d   = clear_on_read;
                end else if (!empty) begin
                    state_d    = INC_RD;
                    pop        = 1'b1;
                    inc_addr_d = head;
                end
            end
            INC_RD: state_d = INC_WR;
            INC_WR: state_d = IDLE;
            CLR: begin
                state_d = (&addr_q) ? IDLE : CLR;
                addr_d  = (&addr_q) ? addr_q : addr_q + 1'b1;
            end
            DMP_RD: state_d = DMP_HOLD;
            DMP_HOLD: begin
                if (bus.dump_ready) begin
                    state_d = (&addr_q) ? IDLE : DMP_RD;
                    addr_d  = (&addr_q) ? addr_q : addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data arrives in the first HOLD cycle; afterwards the registered copy is presented.
    assign bus.dump_data  = (state_q == DMP_HOLD && fresh_q) ? bus.ram_rdata : data_q;
    assign bus.dump_valid = state_q == DMP_HOLD;
    assign bus.dump_addr  = addr_q;
    assign bus.ram_addr   = (state_q == INC_RD || state_q == INC_WR) ? inc_addr_q : addr_q;
    assign bus.ram_we     = state_q == INC_WR || state_q == CLR ||
                            (state_q == DMP_HOLD && cor_q && bus.dump_ready);
    assign bus.ram_wdata  = state_q != INC_WR ? '0 :
                            (&bus.ram_rdata) ? bus.ram_rdata : bus.ram_rdata + 1'b1;
    assign busy           = state_q == CLR || state_q == DMP_RD || state_q == DMP_HOLD;
    assign drop_count     = drop_q;
endmodule

// File: tb/tb_histogram_ram_controller.sv
// tb_histogram_ram_controller: directed bench with a behavioural histogram model and
// a per-cycle checker of the dump stream and drop counter.
module tb_histogram_ram_controller;
    import hist_pkg::*;
    localparam int N = 256;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, inc_valid, clear_start, dump_start, clear_on_read, busy, fifo_full;
    logic [7:0]  inc_addr;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    histogram_ram_controller_if #(.ADDR_W(8), .DATA_W(16)) bus();

    histogram_ram_controller #(.ADDR_W(8), .DATA_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .inc_valid(inc_valid), .inc_addr(inc_addr),
        .clear_start(clear_start), .dump_start(dump_start), .clear_on_read(clear_on_read),
        .busy(busy), .fifo_full(fifo_full), .drop_count(drop_count), .bus(bus)
    );

    logic [15:0] ram [N];
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    int          tests = 0, failed = 0, beat_idx = 0, busy_run = 0;
    logic [15:0] exp_mem [N];
    logic [15:0] dumped [N];
    logic [15:0] drop_exp = '0;
    logic [15:0] prev_data = '0;
    logic        prev_hold = 1'b0;
    int          pend [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: pending increments wait in a bounded queue, dropped when it is full.
    task automatic pulse(input logic [7:0] a);
        inc_valid = 1'b1;
        inc_addr  = a;
        tick();
        inc_valid = 1'b0;
        if (pend.size() < DEPTH) pend.push_back(int'(a));
        else if (drop_exp != 16'hFFFF) drop_exp = drop_exp + 1'b1;
    endtask

    task automatic settle();
        for (int i = 0; i < 1000 && busy; i++) tick();
        chk("settle_idle", busy, 0);
        repeat (3 * DEPTH + 8) tick();
        foreach (pend[i]) if (exp_mem[pend[i]] != SAT_ONES) exp_mem[pend[i]] = exp_mem[pend[i]] + 1'b1;
        pend.delete();
    endtask

    task automatic run_dump(input logic cor, input logic toggle);
        beat_idx      = 0;
        clear_on_read = cor;
        dump_start    = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int i = 0; i < 3000 && beat_idx < N; i++) begin
            bus.dump_ready = toggle ? ~bus.dump_ready : 1'b1;
            tick();
        end
        bus.dump_ready = 1'b0;
        repeat (3) tick();
        chk("dump_beats", beat_idx, N);
        chk("dump_done_idle", {busy, bus.dump_valid}, 0);
        if (cor) foreach (exp_mem[i]) exp_mem[i] = '0;
    endtask

    task automatic check_reset_outs();
        chk("rst_flags", {busy, fifo_full, bus.dump_valid, bus.ram_we}, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_dump_addr", bus.dump_addr, 0);
        chk("rst_dump_data", bus.dump_data, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_wdata", bus.ram_wdata, 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (busy) busy_run++;
            chk("drop_count", drop_count, drop_exp);
            if (bus.dump_valid) begin
                if (prev_hold) chk("dump_hold", bus.dump_data, prev_data);
                chk("dump_addr", bus.dump_addr, beat_idx);
                chk("dump_data", bus.dump_data, exp_mem[beat_idx % N]);
                if (bus.dump_ready) begin
                    dumped[beat_idx % N] = bus.dump_data;
                    beat_idx++;
                end
            end
            prev_hold = bus.dump_valid && !bus.dump_ready;
            prev_data = bus.dump_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        foreach (ram[i]) begin
            ram[i]     = '0;
            exp_mem[i] = '0;
            dumped[i]  = '0;
        end
        rst = 1'b1; inc_valid = 1'b0; inc_addr = '0; clear_start = 1'b0;
        dump_start = 1'b0; clear_on_read = 1'b0; bus.dump_ready = 1'b0;
        repeat (3) tick();
        check_reset_outs();
        rst = 1'b0;
        tick();

        // Three separated increments to bin 128, then a plain dump.
        for (int i = 0; i < 3; i++) begin
            pulse(8'd128);
            repeat (4) tick();
        end
        settle();
        run_dump(1'b0, 1'b0);
        chk("bin128_is_3", dumped[128], 3);
        chk("bin127_is_0", dumped[127], 0);

        // Ten back-to-back increments to bin 5 while a clear keeps the queue from draining.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        foreach (exp_mem[i]) exp_mem[i] = '0;
        for (int i = 0; i < 10; i++) pulse(8'd5);
        chk("fifo_full", fifo_full, 1);
        chk("drop_is_2", drop_count, 2);
        settle();
        run_dump(1'b0, 1'b0);
        chk("bin5_is_8", dumped[5], 8);
        chk("bin5_vs_drop", dumped[5], 32'(10 - int'(drop_count)));
        chk("bin128_cleared", dumped[128], 0);

        // Saturation at all-ones.
        ram[7]     = 16'hFFFE;
        exp_mem[7] = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            pulse(8'd7);
            repeat (4) tick();
        end
        settle();
        run_dump(1'b0, 1'b0);
        chk("bin7_sat", dumped[7], SAT_ONES);

        // Clear-on-read with a toggling consumer, then a second dump must be all zero.
        run_dump(1'b1, 1'b1);
        chk("cor_bin5", dumped[5], 8);
        run_dump(1'b0, 1'b0);
        chk("cor_zero5", dumped[5], 0);
        chk("cor_zero7", dumped[7], 0);

        // Clear with four increments to bin 200 queued behind it.
        busy_run    = 0;
        clear_start = 1'b1;
        inc_valid   = 1'b1;
        inc_addr    = 8'd200;
        tick();
        clear_start = 1'b0;
        inc_valid   = 1'b0;
        foreach (exp_mem[i]) exp_mem[i] = '0;
        pend.push_back(200);
        for (int i = 0; i < 3; i++) pulse(8'd200);
        settle();
        chk("clear_busy_len", busy_run, N);
        run_dump(1'b0, 1'b0);
        chk("bin200_is_4", dumped[200], 4);

        // Reset in the middle of a dump, then a fresh dump.
        beat_idx      = 0;
        clear_on_read = 1'b0;
        dump_start    = 1'b1;
        tick();
        dump_start     = 1'b0;
        bus.dump_ready = 1'b1;
        repeat (40) tick();
        rst = 1'b1;
        tick();
        drop_exp = '0;
        check_reset_outs();
        rst            = 1'b0;
        bus.dump_ready = 1'b0;
        tick();
        run_dump(1'b0, 1'b0);
        chk("post_rst_bin200", dumped[200], 4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/histogram_ram_controller.md
Name: histogram_ram_controller

Overview:
- Owns the single-port histogram block RAM that the time-correlation plot stage targets.
- Queues bin-increment requests (address plus one-cycle strobe) and applies each as a saturating read-modify-write.
- Sequences two host operations, each mutually exclusive with increments:
  - whole-memory clear;
  - streamed bin readout, with optional clear-on-read.

Parameters:
- ADDR_W, 8, histogram bin address width; the number of bins is 2^ADDR_W.
- DATA_W, 16, bin counter width.
- FIFO_DEPTH, 8, pending-increment queue depth; must be a power of two.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- inc_valid  in  1  one-cycle increment request
- inc_addr  in  ADDR_W  bin to increment
- clear_start  in  1  pulse: zero all bins
- dump_start  in  1  pulse: stream all bins out
- clear_on_read  in  1  sampled at dump_start; zero each bin after it is transferred
- dump_valid  out  1  dump_addr/dump_data valid
- dump_ready  in  1  consumer accepts the current bin
- dump_addr  out  ADDR_W  bin index being presented
- dump_data  out  DATA_W  bin count being presented
- busy  out  1  clear or dump in progress
- fifo_full  out  1  increment queue full
- drop_count  out  16  increments lost to a full queue; saturates at 0xFFFF
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after the address is presented

Behaviour:
- Reset:
  - state is IDLE;
  - FIFO is empty;
  - all outputs are 0, including drop_count.
  - Reset mid-operation abandons the operation; RAM contents are left as they are.
- FIFO:
  - A request is pushed on any cycle where inc_valid=1 and the queue is not full, in every state, including during a clear or dump.
  - When full, the request is dropped and drop_count is incremented, saturating at 0xFFFF.
  - A simultaneous push and pop on a full queue is accepted.
- FSM states: IDLE, INC_RD, INC_WR, CLR, DMP_RD, DMP_HOLD.
- IDLE priority order:
  1. clear_start goes to CLR at address 0.
  2. dump_start latches clear_on_read and goes to DMP_RD at address 0.
  3. A non-empty FIFO pops its head and goes to INC_RD.
- A start pulse that arrives outside IDLE is ignored, so a single pulse only takes effect if the FSM is in IDLE on that cycle.
- Increment sequence:
  - INC_RD drives ram_addr = the popped address with ram_we=0.
  - INC_WR writes ram_rdata+1 to the same address, or holds all-ones if ram_rdata is all-ones (saturation).
  - INC_WR returns to IDLE, so each increment takes 3 cycles including the IDLE decision cycle.
  - Back-to-back increments to the same address stay correct because each write completes before the next read is issued.
- CLR:
  - Writes 0 to one address per cycle, from 0 up to 2^ADDR_W-1, then returns to IDLE.
  - busy=1 for exactly 2^ADDR_W cycles.
- DMP_RD: drives ram_addr with ram_we=0.
- DMP_HOLD:
  - dump_valid=1, dump_data=ram_rdata (registered on entry and held stable while ready is low), dump_addr = the current address.
  - On valid&&ready:
    - if clear_on_read was latched, write 0 to the current address in that same cycle;
    - at the last address, return to IDLE; otherwise increment the address and go to DMP_RD.
  - No wrap-around: the address counter stops after the last bin.
- busy is 1 whenever the state is CLR, DMP_RD or DMP_HOLD.
- Increments that queue during a clear or dump are applied afterwards, so they are neither lost by the clear nor counted into the dumped values.

Decomposition:
- Shared package hist_pkg holds:
  - the ADDR_W and DATA_W defaults;
  - the FSM state enum;
  - the saturating-increment constant (all-ones of DATA_W).
- One sub-module, inc_fifo: a synchronous FIFO with push, pop, full, empty and head outputs, parameterised by width and depth.

Test Plan:
- Reset, then inc_addr=128 ×3 separated by idle gaps, then dump without clear -> bin 128 reads 3, all other bins read 0, and 256 beats are transferred.
- Pulse inc_valid for 10 consecutive cycles to address 5 (FIFO_DEPTH=8) -> fifo_full asserts, and a later dump shows bin5 = 10 - drop_count, with drop_count ≥ 1.
- Preload bin 7 = 0xFFFE, then apply 3 increments -> bin 7 = 0xFFFF.
- Dump with clear_on_read=1, with dump_ready toggling at 50% -> dump_data stays stable while ready is low, and a second dump returns all zeros.
- Issue clear_start while 4 increments to address 200 are queued -> busy lasts 256 cycles, then bin200 = 4.
- Assert rst in the middle of a dump -> all outputs are 0 on the next cycle, and a new dump_start is accepted and runs normally.
